// File: rtl/uart_tx_unit.sv
// uart_tx_unit: 8N1 UART serializer with a runtime 16x oversample divisor.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_unit #(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int TIMER_BITS = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [TIMER_BITS-1:0] TIMER_FINAL_VALUE,
  input  logic                  tx_start,
  input  logic [DBIT-1:0]       din,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done_tick,
  output logic [2:0]            state_dbg
);

  // Handshake: tx_start is a request taken only when tx_busy is low (state IDLE);
  // a request while busy is dropped, never queued. tx_done_tick is a one-cycle
  // completion strobe issued on the edge tx_busy falls, usable as a FIFO pop.

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
    ,
    PARITY = 3'd4
`endif
  } state_t;

  localparam logic [4:0]            BIT_LAST  = 5'd15;
  localparam logic [4:0]            SB_LAST   = 5'(SB_TICK - 1);
  localparam logic [2:0]            DBIT_LAST = 3'(DBIT - 1);
  localparam logic [TIMER_BITS-1:0] TIMER_ONE = TIMER_BITS'(1);

  state_t                  state_q, state_d;
  logic [TIMER_BITS-1:0]   timer_q;
  logic [TIMER_BITS-1:0]   tfv_q, tfv_d;
  logic [4:0]              s_cnt_q, s_cnt_d;
  logic [2:0]              n_cnt_q, n_cnt_d;
  logic [DBIT-1:0]         shift_q, shift_d;
  logic [DBIT-1:0]         shift_nxt;
  logic                    tx_q, tx_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    s_tick;
`ifdef UART_TX_PARITY_EN
  logic                    parity_q, parity_d;
`endif

  assign s_tick    = (timer_q == tfv_q);
  assign shift_nxt = shift_q >> 1;

  // Baud timer idles at zero so it restarts cleanly on frame acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q <= '0;
    end else if (state_q == IDLE || s_tick) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + TIMER_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      tfv_q    <= '0;
      s_cnt_q  <= '0;
      n_cnt_q  <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      tfv_q    <= tfv_d;
      s_cnt_q  <= s_cnt_d;
      n_cnt_q  <= n_cnt_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    tfv_d    = tfv_q;
    s_cnt_d  = s_cnt_q;
    n_cnt_d  = n_cnt_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    unique case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (tx_start) begin
          state_d  = START;
          tfv_d    = TIMER_FINAL_VALUE;
          shift_d  = din;
          s_cnt_d  = '0;
          n_cnt_d  = '0;
          tx_d     = 1'b0;
          busy_d   = 1'b1;
`ifdef UART_TX_PARITY_EN
          parity_d = ^din;
`endif
        end
      end
      START: begin
        if (s_tick) begin
          if (s_cnt_q == BIT_LAST) begin
            state_d = DATA;
            s_cnt_d = '0;
            tx_d    = shift_q[0];
          end else begin
            s_cnt_d = s_cnt_q + 5'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_cnt_q == BIT_LAST) begin
            s_cnt_d = '0;
            shift_d = shift_nxt;
            if (n_cnt_q == DBIT_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_d = PARITY;
              tx_d    = parity_q;
`else
              state_d = STOP;
              tx_d    = 1'b1;
`endif
            end else begin
              n_cnt_d = n_cnt_q + 3'd1;
              tx_d    = shift_nxt[0];
            end
          end else begin
            s_cnt_d = s_cnt_q + 5'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (s_cnt_q == BIT_LAST) begin
            state_d = STOP;
            s_cnt_d = '0;
            tx_d    = 1'b1;
          end else begin
            s_cnt_d = s_cnt_q + 5'd1;
          end
        end
      end
`endif
      STOP: begin
        // Final stop tick: done pulse and busy drop land on the same edge.
        if (s_tick) begin
          if (s_cnt_q == SB_LAST) begin
            state_d = IDLE;
            s_cnt_d = '0;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            s_cnt_d = s_cnt_q + 5'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign tx           = tx_q;
  assign tx_busy      = busy_q;
  assign tx_done_tick = done_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_uart_tx_unit.sv
// tb_uart_tx_unit: checks uart_tx_unit (1 and 1.5 stop-bit builds side by side)
// against a frame-level waveform model derived from bit times and frame lengths.
module tb_uart_tx_unit;

  localparam int DBIT = 8;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] tfv = '0;
  logic        tx_start = 1'b0;
  logic [7:0]  din = '0;
  logic        tx_a, busy_a, done_a;
  logic        tx_b, busy_b, done_b;
  logic [2:0]  st_a, st_b;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  uart_tx_unit #(.DBIT(8), .SB_TICK(16), .TIMER_BITS(11)) dut_a (
    .clk(clk), .reset(reset), .TIMER_FINAL_VALUE(tfv), .tx_start(tx_start), .din(din),
    .tx(tx_a), .tx_busy(busy_a), .tx_done_tick(done_a), .state_dbg(st_a));

  uart_tx_unit #(.DBIT(8), .SB_TICK(24), .TIMER_BITS(11)) dut_b (
    .clk(clk), .reset(reset), .TIMER_FINAL_VALUE(tfv), .tx_start(tx_start), .din(din),
    .tx(tx_b), .tx_busy(busy_b), .tx_done_tick(done_b), .state_dbg(st_b));

  // Expected {tx, busy, done} for the cycle following edge E_k (E0 = first acceptance).
  // Frames repeat every flen+1 clocks when tx_start is held (one IDLE cycle between).
  function automatic logic [2:0] model(input int k, input int t, input int sb,
                                       input logic [7:0] d0, input logic [7:0] d1, input int nf);
    int bitlen, nbits, flen, f, j, b;
    logic [7:0] d;
    logic bitv;
    bitlen = 16 * (t + 1);
    nbits  = 1 + DBIT + PAR;
    flen   = nbits * bitlen + sb * (t + 1);
    f = k / (flen + 1);
    j = k % (flen + 1);
    if (f >= nf) return 3'b100;
    d = (f == 0) ? d0 : d1;
    if (j == flen) return 3'b101;
    if (j >= nbits * bitlen) return 3'b110;
    b = j / bitlen;
    if (b == 0) bitv = 1'b0;
    else if (b <= DBIT) bitv = d[b-1];
    else bitv = ^d;
    return {bitv, 2'b10};
  endfunction

  function automatic int frame_len(input int t, input int sb);
    return (16 * (1 + DBIT + PAR) + sb) * (t + 1);
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    if ({tx_a, busy_a, done_a} !== 3'b100) begin
      n_err++; $display("FAIL reset_state sb16 got=%b exp=100", {tx_a, busy_a, done_a});
    end
    if ({tx_b, busy_b, done_b} !== 3'b100) begin
      n_err++; $display("FAIL reset_state sb24 got=%b exp=100", {tx_b, busy_b, done_b});
    end
    n_vec += 2;
    tfv = 11'd3; din = 8'($urandom); tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (20) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    if ({tx_a, busy_a, done_a} !== 3'b100) begin
      n_err++; $display("FAIL async_reset sb16 got=%b exp=100", {tx_a, busy_a, done_a});
    end
    if ({tx_b, busy_b, done_b} !== 3'b100) begin
      n_err++; $display("FAIL async_reset sb24 got=%b exp=100", {tx_b, busy_b, done_b});
    end
    n_vec += 2;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      din = 8'($urandom);
      tfv = 11'($urandom_range(0, 7));
      if ({tx_a, busy_a, done_a} !== 3'b100) begin
        n_err++; $display("FAIL idle sb16 k=%0d got=%b exp=100", k, {tx_a, busy_a, done_a});
      end
      if ({tx_b, busy_b, done_b} !== 3'b100) begin
        n_err++; $display("FAIL idle sb24 k=%0d got=%b exp=100", k, {tx_b, busy_b, done_b});
      end
      n_vec += 2;
    end
  endtask

  task automatic test_single_frame();
    logic [2:0] ea, eb;
    int dones;
    dones = 0;
    @(negedge clk);
    tfv = 11'd3; din = 8'hA5; tx_start = 1'b1;
    for (int k = 0; k < 720; k++) begin
      @(negedge clk);
      if (k == 0) tx_start = 1'b0;
      ea = model(k, 3, 16, 8'hA5, 8'h00, 1);
      eb = model(k, 3, 24, 8'hA5, 8'h00, 1);
      if (done_a === 1'b1) dones++;
      if ({tx_a, busy_a, done_a} !== ea) begin
        n_err++; $display("FAIL single sb16 k=%0d got=%b exp=%b", k, {tx_a, busy_a, done_a}, ea);
      end
      if ({tx_b, busy_b, done_b} !== eb) begin
        n_err++; $display("FAIL single sb24 k=%0d got=%b exp=%b", k, {tx_b, busy_b, done_b}, eb);
      end
      n_vec += 2;
    end
    if (dones !== 1) begin
      n_err++; $display("FAIL single_done_count got=%0d exp=1", dones);
    end
    n_vec++;
  endtask

  task automatic test_start_while_busy();
    logic [2:0] ea, eb;
    int dones;
    dones = 0;
    @(negedge clk);
    tfv = 11'd3; din = 8'h3C; tx_start = 1'b1;
    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      if (k == 0) tx_start = 1'b0;
      if (k == 100) tfv = 11'd9;
      if (k == 199) begin tx_start = 1'b1; din = 8'hFF; end
      if (k == 200) tx_start = 1'b0;
      ea = model(k, 3, 16, 8'h3C, 8'h00, 1);
      eb = model(k, 3, 24, 8'h3C, 8'h00, 1);
      if (done_a === 1'b1) dones++;
      if ({tx_a, busy_a, done_a} !== ea) begin
        n_err++; $display("FAIL busy_start sb16 k=%0d got=%b exp=%b", k, {tx_a, busy_a, done_a}, ea);
      end
      if ({tx_b, busy_b, done_b} !== eb) begin
        n_err++; $display("FAIL busy_start sb24 k=%0d got=%b exp=%b", k, {tx_b, busy_b, done_b}, eb);
      end
      n_vec += 2;
    end
    if (dones !== 1) begin
      n_err++; $display("FAIL busy_start_done_count got=%0d exp=1", dones);
    end
    n_vec++;
  endtask

  task automatic test_back_to_back();
    logic [2:0] ea, eb;
    @(negedge clk);
    tfv = 11'd0; din = 8'h00; tx_start = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (k == 0) din = 8'hFF;
      if (k == 2 * (frame_len(0, 16) + 1) - 1) tx_start = 1'b0;
      ea = model(k, 0, 16, 8'h00, 8'hFF, 2);
      eb = model(k, 0, 24, 8'h00, 8'hFF, 2);
      if ({tx_a, busy_a, done_a} !== ea) begin
        n_err++; $display("FAIL b2b sb16 k=%0d got=%b exp=%b", k, {tx_a, busy_a, done_a}, ea);
      end
      if ({tx_b, busy_b, done_b} !== eb) begin
        n_err++; $display("FAIL b2b sb24 k=%0d got=%b exp=%b", k, {tx_b, busy_b, done_b}, eb);
      end
      n_vec += 2;
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [2:0] ea, eb;
    @(negedge clk);
    tfv = 11'd3; din = 8'h55; tx_start = 1'b1;
    for (int k = 0; k < 330; k++) begin
      @(negedge clk);
      if (k == 0) tx_start = 1'b0;
      if (k == 300) begin reset = 1'b1; #1; end
      ea = (k < 300) ? model(k, 3, 16, 8'h55, 8'h00, 1) : 3'b100;
      eb = (k < 300) ? model(k, 3, 24, 8'h55, 8'h00, 1) : 3'b100;
      if ({tx_a, busy_a, done_a} !== ea) begin
        n_err++; $display("FAIL reset_mid sb16 k=%0d got=%b exp=%b", k, {tx_a, busy_a, done_a}, ea);
      end
      if ({tx_b, busy_b, done_b} !== eb) begin
        n_err++; $display("FAIL reset_mid sb24 k=%0d got=%b exp=%b", k, {tx_b, busy_b, done_b}, eb);
      end
      n_vec += 2;
      if (k == 310) reset = 1'b0;
    end
    tx_start = 1'b1;
    for (int k = 0; k < 700; k++) begin
      @(negedge clk);
      if (k == 0) tx_start = 1'b0;
      ea = model(k, 3, 16, 8'h55, 8'h00, 1);
      eb = model(k, 3, 24, 8'h55, 8'h00, 1);
      if ({tx_a, busy_a, done_a} !== ea) begin
        n_err++; $display("FAIL after_reset sb16 k=%0d got=%b exp=%b", k, {tx_a, busy_a, done_a}, ea);
      end
      if ({tx_b, busy_b, done_b} !== eb) begin
        n_err++; $display("FAIL after_reset sb24 k=%0d got=%b exp=%b", k, {tx_b, busy_b, done_b}, eb);
      end
      n_vec += 2;
    end
  endtask

  task automatic test_random_frames();
    logic [2:0] ea, eb;
    logic [7:0] d;
    int t, kc, ncyc;
    for (int n = 0; n < 6; n++) begin
      t = $urandom_range(0, 4);
      d = 8'($urandom);
      ncyc = frame_len(t, 24) + 8;
      kc = $urandom_range(1, ncyc / 2);
      @(negedge clk);
      tfv = 11'(t); din = d; tx_start = 1'b1;
      for (int k = 0; k < ncyc; k++) begin
        @(negedge clk);
        if (k == 0) tx_start = 1'b0;
        if (k == kc) begin tfv = 11'($urandom_range(0, 20)); din = 8'($urandom); end
        ea = model(k, t, 16, d, 8'h00, 1);
        eb = model(k, t, 24, d, 8'h00, 1);
        if ({tx_a, busy_a, done_a} !== ea) begin
          n_err++; $display("FAIL random sb16 t=%0d din=%h k=%0d got=%b exp=%b", t, d, k, {tx_a, busy_a, done_a}, ea);
        end
        if ({tx_b, busy_b, done_b} !== eb) begin
          n_err++; $display("FAIL random sb24 t=%0d din=%h k=%0d got=%b exp=%b", t, d, k, {tx_b, busy_b, done_b}, eb);
        end
        n_vec += 2;
      end
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [7:0] vals [2];
    logic [2:0] ea;
    int busy_cnt;
    vals[0] = 8'h07;
    vals[1] = 8'h03;
    for (int n = 0; n < 2; n++) begin
      busy_cnt = 0;
      @(negedge clk);
      tfv = 11'd3; din = vals[n]; tx_start = 1'b1;
      for (int k = 0; k < 720; k++) begin
        @(negedge clk);
        if (k == 0) tx_start = 1'b0;
        if (busy_a === 1'b1) busy_cnt++;
        ea = model(k, 3, 16, vals[n], 8'h00, 1);
        if ({tx_a, busy_a, done_a} !== ea) begin
          n_err++; $display("FAIL parity din=%h k=%0d got=%b exp=%b", vals[n], k, {tx_a, busy_a, done_a}, ea);
        end
        n_vec++;
      end
      if (busy_cnt !== 704) begin
        n_err++; $display("FAIL parity_frame_len din=%h got=%0d exp=704", vals[n], busy_cnt);
      end
      n_vec++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_frame();
    test_random_frames();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_unit.md
Name: uart_tx_unit

Overview:
Standalone UART serializer: the transmit end of the 8N1 link the terminal receiver consumes.
- Takes a parallel byte with a one-cycle start strobe.
- Generates its own 16x oversampling tick from a runtime divisor.
- Shifts out start, data (LSB first), optional parity and stop bits on `tx`.
- Sits between a TX FIFO (or push-button edge) and the board TX pin; `tx_done_tick` is the FIFO pop strobe.

Parameters:
- DBIT, 8, number of data bits per frame (6..8).
- SB_TICK, 16, stop-bit length in oversample ticks (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- TIMER_BITS, 11, width of the baud divisor input.

Ports:
- clk  input  1  system clock (100 MHz on board).
- reset  input  1  asynchronous, active-high reset.
- TIMER_FINAL_VALUE  input  TIMER_BITS  oversample divisor; tick period = TIMER_FINAL_VALUE+1 clocks.
- tx_start  input  1  request to send `din`; sampled only in IDLE.
- din  input  DBIT  byte to transmit.
- tx  output  1  serial line, idle high.
- tx_busy  output  1  high while a frame is in progress (state != IDLE).
- tx_done_tick  output  1  one-cycle pulse at end of stop bit.

Behaviour:
- Reset, applied asynchronously:
  - `tx`=1, `tx_busy`=0, `tx_done_tick`=0.
  - State IDLE; shift register, tick counter, bit counter and baud timer all cleared.
- Baud timer:
  - Divisor and timer are latched/restarted at frame acceptance, so mid-frame changes to `TIMER_FINAL_VALUE` do not affect the current frame.
  - Counts 0..T; emits `s_tick` on the cycle it equals T, then wraps to 0. T is the latched value.
  - One bit = 16 ticks = 16*(T+1) clocks. T=650 gives 9600 baud at 100 MHz.
- States and transitions:
  - IDLE: `tx`=1. If `tx_start`=1 at edge E0: latch `din` and T, go to START, clear counters. `tx`=0 from E0 onward.
  - START: `tx`=0 for 16 ticks, then go to DATA.
  - DATA: `tx`=shift_reg[0] for 16 ticks per bit; shift right after each bit; after DBIT bits go to STOP (or PARITY when enabled).
  - STOP: `tx`=1 for SB_TICK ticks. On the final tick, pulse `tx_done_tick` for exactly that cycle and return to IDLE on the same edge.
- Frame length (no parity) = (16*(1+DBIT)+SB_TICK)*(T+1) clocks, measured from E0 to the edge where `tx_busy` falls.
- `tx_busy`: registered, high from E0 until the IDLE return edge.
- `tx_start` while busy: ignored, never queued. `din` changes while busy: ignored.
- Back-to-back: if `tx_start` is held high, the next frame is accepted on the first IDLE cycle, one clock after `tx_done_tick`. The stop bit is never shortened.
- Reset mid-frame: `tx` returns high immediately and no `tx_done_tick` is issued.
- T=0 is legal: tick every clock, 16 clocks per bit.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined:
  - PARITY state inserted between DATA and STOP.
  - `tx` = even parity (XOR of all DBIT data bits) for 16 ticks.
  - Frame lengthens by 16*(T+1) clocks.
- When undefined: no PARITY state, no parity logic; DATA goes directly to STOP.

Test Plan:
- Idle after reset: `reset` pulsed asynchronously between edges -> `tx`=1, `tx_busy`=0, `tx_done_tick`=0 immediately; no `tx` toggles for 1000 clocks.
- Single frame, T=3, `din`=0xA5, 1-cycle `tx_start` -> `tx` = 0,1,0,1,0,0,1,0,1,1, each level 64 clocks. `tx_done_tick` is a single pulse on cycle 640 after E0; `tx_busy` falls on that edge.
- Start while busy, T=3: second `tx_start` with `din`=0xFF at clock 200 of the 0x3C frame -> 0x3C frame unchanged; exactly one `tx_done_tick`; `tx` stays 1 afterwards.
- Back-to-back, T=0, `tx_start` held high, `din`=0x00 then 0xFF -> second start bit begins 1 clock after the first `tx_done_tick`; each frame 160 clocks; SB_TICK=24 variant gives 168-clock frames.
- Reset mid-frame, T=3: `reset` asserted at clock 300 of a 0x55 frame -> `tx`=1 asynchronously, no `tx_done_tick`; a new 0x55 frame after release is bit-exact.
- Parity (UART_TX_PARITY_EN), T=3: `din`=0x07 -> parity bit 1; `din`=0x03 -> parity bit 0; each parity bit 64 clocks; frame 704 clocks.
